// File: rtl/wb_pkg.sv
// Shared load-type encodings, load-queue entry type and load alignment helper
// for the register-file write-back path.
package wb_pkg;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] ltype;
        logic [1:0] off;
    } lq_entry_t;

    // Big-endian lane select: offset 0 is the most significant byte.
    function automatic logic [31:0] align_load(input logic [2:0]  ltype,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
        logic [7:0]  byte_s;
        logic [15:0] half_s;
        logic [31:0] res_s;
        case (off)
            2'd0:    byte_s = word[31:24];
            2'd1:    byte_s = word[23:16];
            2'd2:    byte_s = word[15:8];
            2'd3:    byte_s = word[7:0];
            default: byte_s = word[7:0];
        endcase
        half_s = off[1] ? word[15:0] : word[31:16];
        case (ltype)
            LT_LB:   res_s = {{24{byte_s[7]}}, byte_s};
            LT_LBU:  res_s = {24'h00_0000, byte_s};
            LT_LH:   res_s = {{16{half_s[15]}}, half_s};
            LT_LHU:  res_s = {16'h0000, half_s};
            default: res_s = word;
        endcase
        return res_s;
    endfunction

endpackage

// File: rtl/load_queue.sv
// In-order FIFO of outstanding load tags. A push is taken when not full, or
// when full together with a pop, so the count is unchanged in that case.
module load_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   push,
    input  lq_entry_t              push_entry,
    input  logic                   pop,
    output lq_entry_t              head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    lq_entry_t     mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          full_s;
    logic          empty_s;
    logic          do_push_s;
    logic          do_pop_s;

    // Status flags and effective push/pop qualification.
    always_comb begin
        full_s    = (count_r == CNT_FULL);
        empty_s   = (count_r == {(AW+1){1'b0}});
        do_pop_s  = pop & ~empty_s;
        do_push_s = push & (~full_s | do_pop_s);
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge Clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= push_entry;
    end

    // Head entry and status outputs.
    always_comb begin
        head  = mem_r[rd_ptr_r];
        count = count_r;
        full  = full_s;
        empty = empty_s;
    end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write port driver: merges ALU results and in-order load returns.
// Optional decode bypass outputs are enabled with the WB_FWD_EN macro.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH = 4
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      AluValid,
    input  logic [4:0]                AluRd,
    input  logic [31:0]               AluData,
    output logic                      AluReady,
    input  logic                      LdIssue,
    input  logic [4:0]                LdRd,
    input  logic [2:0]                LdType,
    input  logic [1:0]                LdOff,
    output logic                      LdReady,
    input  logic                      MemRespValid,
    input  logic [31:0]               MemRespData,
    output logic                      RegWr,
    output logic [4:0]                RW,
    output logic [31:0]               BusW,
    output logic                      LdErr,
    output logic [$clog2(LQ_DEPTH):0] LqCount
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]                RA,
    input  logic [4:0]                RB,
    output logic                      FwdA,
    output logic                      FwdB,
    output logic [31:0]               FwdData
`endif
);

    localparam int CW = $clog2(LQ_DEPTH) + 1;

    lq_entry_t      push_entry_s;
    lq_entry_t      head_s;
    logic [CW-1:0]  lq_count_s;
    logic           lq_full_s;
    logic           lq_empty_s;
    logic           mem_win_s;
    logic           regwr_r;
    logic [4:0]     rw_r;
    logic [31:0]    busw_r;
    logic           lderr_r;

    load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
        .Clk        (Clk),
        .Rst        (Rst),
        .push       (LdIssue),
        .push_entry (push_entry_s),
        .pop        (mem_win_s),
        .head       (head_s),
        .count      (lq_count_s),
        .full       (lq_full_s),
        .empty      (lq_empty_s)
    );

    // Load responses beat the ALU; a stray response never stalls it.
    always_comb begin
        push_entry_s = '{rd: LdRd, ltype: LdType, off: LdOff};
        mem_win_s    = MemRespValid & ~lq_empty_s;
        AluReady     = ~mem_win_s;
        LdReady      = ~lq_full_s;
        LqCount      = lq_count_s;
    end

    // Write-port register: r0 results are consumed but leave RW/BusW untouched.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            regwr_r <= 1'b0;
            rw_r    <= 5'd0;
            busw_r  <= 32'h0000_0000;
            lderr_r <= 1'b0;
        end else begin
            if (mem_win_s) begin
                regwr_r <= (head_s.rd != 5'd0);
                if (head_s.rd != 5'd0) begin
                    rw_r   <= head_s.rd;
                    busw_r <= align_load(head_s.ltype, head_s.off, MemRespData);
                end
            end else if (AluValid) begin
                regwr_r <= (AluRd != 5'd0);
                if (AluRd != 5'd0) begin
                    rw_r   <= AluRd;
                    busw_r <= AluData;
                end
            end else begin
                regwr_r <= 1'b0;
            end
            if (MemRespValid & lq_empty_s) lderr_r <= 1'b1;
        end
    end

    // Registered outputs to the register file.
    always_comb begin
        RegWr = regwr_r;
        RW    = rw_r;
        BusW  = busw_r;
        LdErr = lderr_r;
    end

`ifdef WB_FWD_EN
    // Bypass of the value being written this cycle to the decode read ports.
    always_comb begin
        FwdA    = regwr_r & (rw_r == RA) & (RA != 5'd0);
        FwdB    = regwr_r & (rw_r == RB) & (RB != 5'd0);
        FwdData = busw_r;
    end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: driver predicts writes from a queue-level
// model, a negedge monitor compares every RF write and status output.
module tb_reg_writeback;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Rst, AluValid, LdIssue, MemRespValid;
    logic [4:0]  AluRd, LdRd;
    logic [31:0] AluData, MemRespData;
    logic [2:0]  LdType;
    logic [1:0]  LdOff;
    logic        AluReady, LdReady, RegWr, LdErr;
    logic [4:0]  RW;
    logic [31:0] BusW;
    logic [2:0]  LqCount;
`ifdef WB_FWD_EN
    logic [4:0]  RA = 5'd0, RB = 5'd0;
    logic        FwdA, FwdB;
    logic [31:0] FwdData;
`endif

    reg_writeback #(.LQ_DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst),
        .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData), .AluReady(AluReady),
        .LdIssue(LdIssue), .LdRd(LdRd), .LdType(LdType), .LdOff(LdOff), .LdReady(LdReady),
        .MemRespValid(MemRespValid), .MemRespData(MemRespData),
        .RegWr(RegWr), .RW(RW), .BusW(BusW), .LdErr(LdErr), .LqCount(LqCount)
`ifdef WB_FWD_EN
        , .RA(RA), .RB(RB), .FwdA(FwdA), .FwdB(FwdB), .FwdData(FwdData)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] t;
        logic [1:0] o;
    } ld_t;

    ld_t          lq[$];
    logic [36:0]  sbq[$];
    int           n_checks = 0;
    int           n_fail = 0;
    bit           mon_en = 1'b0;
    bit           final_req = 1'b0;
    bit           final_done = 1'b0;
    bit           exp_alu_ready, exp_ld_ready;
    int           exp_count = 0;
    bit           exp_err_cur = 1'b0;
    bit           exp_err_next = 1'b0;
    bit           alu_acc;
    logic [4:0]   last_rw = 5'd0;
    logic [31:0]  last_busw = 32'h0;

    function automatic logic [31:0] ref_load(logic [2:0] t, logic [1:0] o, logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * (3 - o))) & 32'hFF;
        h = o[1] ? (w & 32'hFFFF) : (w >> 16);
        case (t)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock of stimulus; the model decides what is accepted this cycle.
    task automatic step(input bit rst, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit li, input logic [4:0] lrd, input logic [2:0] lt, input logic [1:0] lo,
                        input bit rv, input logic [31:0] rdat);
        int  sz;
        bit  win;
        ld_t e;
        @(posedge Clk);
        #1;
        Rst = rst; AluValid = av; AluRd = ard; AluData = ad;
        LdIssue = li; LdRd = lrd; LdType = lt; LdOff = lo;
        MemRespValid = rv; MemRespData = rdat;
        exp_err_cur   = exp_err_next;
        sz            = lq.size();
        win           = rv && (sz > 0);
        exp_alu_ready = !win;
        exp_ld_ready  = (sz < DEPTH);
        exp_count     = sz;
        alu_acc       = 1'b0;
        if (rst) begin
            lq.delete();
            exp_err_next = 1'b0;
        end else begin
            if (win) begin
                e = lq.pop_front();
                if (e.rd != 5'd0) sbq.push_back({e.rd, ref_load(e.t, e.o, rdat)});
            end else if (av) begin
                alu_acc = 1'b1;
                if (ard != 5'd0) sbq.push_back({ard, ad});
            end
            if (rv && !win) exp_err_next = 1'b1;
            if (li && (sz < DEPTH || win)) lq.push_back('{rd: lrd, t: lt, o: lo});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'h0);
    endtask

    task automatic resp(input logic [31:0] d);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, d);
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] t, input logic [1:0] o);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, rd, t, o, 1'b0, 32'h0);
    endtask

    // Monitor: checks status outputs and pops the scoreboard on every RF write.
    always @(negedge Clk) begin
        logic [36:0] w;
        bit          wrote;
        wrote = 1'b0;
        w     = 37'h0;
        if (mon_en) begin
            chk("AluReady", {31'h0, AluReady}, {31'h0, exp_alu_ready});
            chk("LdReady", {31'h0, LdReady}, {31'h0, exp_ld_ready});
            chk("LqCount", {29'h0, LqCount}, 32'(exp_count));
            chk("LdErr", {31'h0, LdErr}, {31'h0, exp_err_cur});
            if (RegWr === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected RegWr", {27'h0, RW}, 32'hFFFF_FFFF);
                end else begin
                    w = sbq.pop_front();
                    wrote = 1'b1;
                    chk("RW", {27'h0, RW}, {27'h0, w[36:32]});
                    chk("BusW", BusW, w[31:0]);
                    last_rw   = w[36:32];
                    last_busw = w[31:0];
                end
            end else begin
                chk("RegWr idle", {31'h0, RegWr}, 32'h0);
                chk("RW hold", {27'h0, RW}, {27'h0, last_rw});
                chk("BusW hold", BusW, last_busw);
            end
`ifdef WB_FWD_EN
            chk("FwdA", {31'h0, FwdA}, {31'h0, wrote && (w[36:32] == RA) && (RA != 5'd0)});
            chk("FwdB", {31'h0, FwdB}, {31'h0, wrote && (w[36:32] == RB) && (RB != 5'd0)});
            if (wrote) chk("FwdData", FwdData, w[31:0]);
`endif
            if (Rst) begin
                last_rw   = 5'd0;
                last_busw = 32'h0;
            end
            if (final_req && !final_done) begin
                chk("scoreboard drained", 32'(sbq.size()), 32'h0);
                final_done = 1'b1;
            end
        end
    end

    initial begin
        bit          av;
        logic [4:0]  ard;
        logic [31:0] ad;
        bit          rv;
        Rst = 1'b1; AluValid = 1'b0; AluRd = 5'd0; AluData = 32'h0;
        LdIssue = 1'b0; LdRd = 5'd0; LdType = 3'd0; LdOff = 2'd0;
        MemRespValid = 1'b0; MemRespData = 32'h0;
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'h0);
        mon_en = 1'b1;
        idle(2);
        // ALU only
        step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'h0);
        idle(2);
        // Two loads, in-order alignment
        issue(5'd3, 3'b000, 2'd1);
        issue(5'd4, 3'b101, 2'd1);
        resp(32'h1280_34FF);
        resp(32'h1234_ABCD);
        idle(2);
        // Response and ALU in the same cycle: ALU stalls one cycle
        issue(5'd6, 3'b010, 2'd3);
        step(1'b0, 1'b1, 5'd9, 32'h1111_2222, 1'b0, 5'd0, 3'd0, 2'd0, 1'b1, 32'hCAFE_F00D);
        step(1'b0, 1'b1, 5'd9, 32'h1111_2222, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'h0);
        idle(1);
        // Fill the queue, 5th issue dropped, push+pop at full
        issue(5'd1, 3'b000, 2'd0);
        issue(5'd2, 3'b001, 2'd0);
        issue(5'd8, 3'b010, 2'd2);
        issue(5'd10, 3'b100, 2'd3);
        issue(5'd11, 3'b010, 2'd0);
        step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 3'b001, 2'd2, 1'b1, 32'h8081_8283);
        idle(1);
        resp(32'hF0E1_D2C3);
        resp(32'h0102_0304);
        resp(32'hA5A5_5A5A);
        resp(32'h7788_99AA);
        idle(1);
        // Stray response, r0 load and r0 ALU result
        resp(32'h5555_5555);
        issue(5'd0, 3'b010, 2'd0);
        resp(32'h1357_9BDF);
        step(1'b0, 1'b1, 5'd0, 32'h2468_ACE0, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'h0);
        idle(2);
`ifdef WB_FWD_EN
        RA = 5'd7; RB = 5'd0;
        step(1'b0, 1'b1, 5'd7, 32'h0BAD_F00D, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'h0);
        idle(1);
        RA = 5'd0;
        step(1'b0, 1'b1, 5'd0, 32'h0BAD_F00E, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'h0);
        idle(1);
`endif
        // Reset mid-operation clears queue, pending write and sticky error
        issue(5'd13, 3'b010, 2'd0);
        step(1'b0, 1'b1, 5'd7, 32'h7777_0007, 1'b1, 5'd14, 3'b000, 2'd1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 5'd15, 32'h1515_1515, 1'b0, 5'd0, 3'd0, 2'd0, 1'b0, 32'h0);
        idle(2);
        // Randomized traffic; a stalled ALU holds its request
        av = 1'b0; ard = 5'd0; ad = 32'h0;
        for (int i = 0; i < 600; i++) begin
            if (!av || alu_acc) begin
                av  = ($urandom_range(0, 99) < 60);
                ard = 5'($urandom_range(0, 31));
                ad  = $urandom;
            end
            rv = ($urandom_range(0, 99) < (lq.size() > 0 ? 45 : 3));
`ifdef WB_FWD_EN
            RA = 5'($urandom_range(0, 31));
            RB = 5'($urandom_range(0, 31));
`endif
            step(1'b0, av, ard, ad, ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 31)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), rv, $urandom);
        end
        for (int i = 0; i < 10; i++) begin
            rv = (lq.size() > 0);
            step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 3'd0, 2'd0, rv, $urandom);
        end
        idle(2);
        final_req = 1'b1;
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
